// File: rtl/event_fifo.sv
// Event buffer between the DVS event encoder and the register file: show-ahead FIFO
// with occupancy, sticky overflow, hysteretic interrupt and windowed event-rate counter.
module event_fifo #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10,
  parameter int DEPTH  = (1 << AWIDTH) - 1,
  parameter int WINDOW = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evt_valid,
  input  logic [DWIDTH-1:0] evt_data,
  output logic              evt_ready,
  input  logic              fifo_rst_n,
  input  logic              fifo_rd_en,
  output logic [DWIDTH-1:0] fifo_rdata,
  output logic [AWIDTH-1:0] fifo_numel,
  output logic              fifo_overflow,
  input  logic [AWIDTH-1:0] irq_assert_thresh,
  input  logic [AWIDTH-1:0] irq_deassert_thresh,
  output logic              irq,
  output logic [AWIDTH-1:0] event_rate
);

  localparam int CW = $clog2(WINDOW);
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] FULL_CNT = AWIDTH'(DEPTH);
  localparam logic [AWIDTH-1:0] SAT_MAX  = '1;
  localparam logic [AWIDTH-1:0] A_ONE    = AWIDTH'(1);
  localparam logic [CW-1:0]     WIN_LAST = CW'(WINDOW - 1);
  localparam logic [CW-1:0]     C_ONE    = CW'(1);

  typedef enum logic {
    IRQ_IDLE,
    IRQ_ASSERTED
  } irq_state_e;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] numel_q, numel_d;
  logic              overflow_q, overflow_d;
  irq_state_e        irq_state_q;
  logic              irq_q;
  logic [CW-1:0]     cyc_q;
  logic [AWIDTH-1:0] acc_q;
  logic [AWIDTH-1:0] rate_q;

  logic full, push, pop, push_acc;

  // Pointers wrap at DEPTH-1 explicitly since DEPTH is not a power of two.
  function automatic logic [AWIDTH-1:0] ptr_inc(input logic [AWIDTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + A_ONE;
  endfunction

  function automatic logic [AWIDTH-1:0] sat_inc(input logic [AWIDTH-1:0] a, input logic inc);
    return (inc && (a != SAT_MAX)) ? a + A_ONE : a;
  endfunction

  assign full      = (numel_q == FULL_CNT);
  assign evt_ready = ~full;
  assign push      = evt_valid & ~full;
  assign pop       = fifo_rd_en & (numel_q != '0);
  assign push_acc  = push & fifo_rst_n;

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    numel_d    = numel_q;
    overflow_d = overflow_q | (evt_valid & full);
    case ({push, pop})
      2'b10:   numel_d = numel_q + A_ONE;
      2'b01:   numel_d = numel_q - A_ONE;
      default: numel_d = numel_q;
    endcase
    if (!fifo_rst_n) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      numel_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      numel_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      numel_q    <= numel_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= evt_data;
    end
  end

  // Hysteretic interrupt, evaluated on the registered occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_state_q <= IRQ_IDLE;
      irq_q       <= 1'b0;
    end else if (!fifo_rst_n || (irq_assert_thresh == '0)) begin
      irq_state_q <= IRQ_IDLE;
      irq_q       <= 1'b0;
    end else begin
      case (irq_state_q)
        IRQ_IDLE: begin
          if (numel_q >= irq_assert_thresh) begin
            irq_state_q <= IRQ_ASSERTED;
            irq_q       <= 1'b1;
          end
        end
        IRQ_ASSERTED: begin
          if (numel_q <= irq_deassert_thresh) begin
            irq_state_q <= IRQ_IDLE;
            irq_q       <= 1'b0;
          end
        end
        default: begin
          irq_state_q <= IRQ_IDLE;
          irq_q       <= 1'b0;
        end
      endcase
    end
  end

  // The last window cycle's push is folded into the published rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      acc_q  <= '0;
      rate_q <= '0;
    end else if (cyc_q == WIN_LAST) begin
      cyc_q  <= '0;
      acc_q  <= '0;
      rate_q <= sat_inc(acc_q, push_acc);
    end else begin
      cyc_q  <= cyc_q + C_ONE;
      acc_q  <= sat_inc(acc_q, push_acc);
    end
  end

  assign fifo_rdata    = (numel_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign fifo_numel    = numel_q;
  assign fifo_overflow = overflow_q;
  assign irq           = irq_q;
  assign event_rate    = rate_q;

endmodule

// File: tb/tb_event_fifo.sv
// Scoreboard bench for event_fifo: directed traffic, popped words checked by a monitor.
module tb_event_fifo;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1023;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          evt_valid = 1'b0;
  logic [DW-1:0] evt_data = '0;
  logic          evt_ready;
  logic          fifo_rst_n = 1'b1;
  logic          fifo_rd_en = 1'b0;
  logic [DW-1:0] fifo_rdata;
  logic [AW-1:0] fifo_numel;
  logic          fifo_overflow;
  logic [AW-1:0] irq_assert_thresh = '0;
  logic [AW-1:0] irq_deassert_thresh = '0;
  logic          irq;
  logic [AW-1:0] event_rate;

  logic          b_valid = 1'b0;
  logic          b_ready;
  logic          b_rd_en = 1'b0;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] b_numel;
  logic          b_overflow;
  logic          b_irq;
  logic [AW-1:0] b_rate;

  event_fifo #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .WINDOW(100)) dut (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .fifo_rst_n(fifo_rst_n), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .fifo_numel(fifo_numel), .fifo_overflow(fifo_overflow),
    .irq_assert_thresh(irq_assert_thresh), .irq_deassert_thresh(irq_deassert_thresh),
    .irq(irq), .event_rate(event_rate)
  );

  event_fifo #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .WINDOW(4096)) dut_b (
    .clk(clk), .rst_n(rst_n), .evt_valid(b_valid), .evt_data(32'hCAFE),
    .evt_ready(b_ready), .fifo_rst_n(1'b1), .fifo_rd_en(b_rd_en),
    .fifo_rdata(b_rdata), .fifo_numel(b_numel), .fifo_overflow(b_overflow),
    .irq_assert_thresh(10'd0), .irq_deassert_thresh(10'd0),
    .irq(b_irq), .event_rate(b_rate)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt  = 0;
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  // One clock of A-side traffic; the model decides acceptance from pre-edge state.
  task automatic cyc(input logic push, input logic [DW-1:0] data, input logic pop);
    bit pop_ok;
    bit push_ok;
    pop_ok  = pop && (mdl.size() != 0);
    push_ok = push && (mdl.size() < DEPTH);
    evt_valid  = push;
    evt_data   = data;
    fifo_rd_en = pop;
    if (pop) begin
      if (pop_ok) sb.push_back(mdl.pop_front());
      else        sb.push_back('0);
    end
    if (push_ok) mdl.push_back(data);
    tick();
    evt_valid  = 1'b0;
    fifo_rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && fifo_rst_n && fifo_rd_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: rdata 0x%0h with no expected word", fifo_rdata);
      end else begin
        mon_exp = sb.pop_front();
        n_cmp++;
        if (fifo_rdata !== mon_exp) begin
          n_err++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", fifo_rdata, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed;
    repeat (3) tick();
    chk("rst_numel", fifo_numel, 0);
    chk("rst_rdata", fifo_rdata, 0);
    chk("rst_ovf", fifo_overflow, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rate", event_rate, 0);
    chk("rst_ready", evt_ready, 1);
    rst_n = 1'b1;
    ecnt  = 0;

    // Rate window 1: 37 pushes, published at edge 100.
    for (int i = 0; i < 37; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
    chk("rate_numel37", fifo_numel, 37);
    repeat (62) cyc(1'b0, '0, 1'b0);
    chk("rate_before_w1", event_rate, 0);
    cyc(1'b0, '0, 1'b0);
    chk("rate_w1", event_rate, 37);
    repeat (37) cyc(1'b0, '0, 1'b1);
    chk("rate_drained", fifo_numel, 0);
    for (int k = 0; k < 200 && ecnt < 199; k++) cyc(1'b0, '0, 1'b0);
    chk("rate_hold", event_rate, 37);
    cyc(1'b0, '0, 1'b0);
    chk("rate_w2_idle", event_rate, 0);

    // Ordering and empty pop.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'(i), 1'b0);
    chk("ord_numel5", fifo_numel, 5);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, 1'b1);
      chk("ord_numel", fifo_numel, 32'(4 - k));
    end
    cyc(1'b0, '0, 1'b1);
    chk("empty_pop_numel", fifo_numel, 0);
    chk("empty_pop_rdata", fifo_rdata, 0);

    // Full and overflow.
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b1, 32'h1000 + 32'(i), 1'b0);
      if (i == 1021) chk("ready_before_full", evt_ready, 1);
      if (i == 1022) begin
        chk("ready_full", evt_ready, 0);
        chk("ovf_not_yet", fifo_overflow, 0);
      end
    end
    chk("full_numel", fifo_numel, 1023);
    chk("full_ready", evt_ready, 0);
    chk("full_ovf", fifo_overflow, 1);
    cyc(1'b1, 32'hDEAD, 1'b1);
    chk("full_pushpop_numel", fifo_numel, 1022);
    chk("full_pushpop_ready", evt_ready, 1);
    repeat (1022) cyc(1'b0, '0, 1'b1);
    chk("full_drained", fifo_numel, 0);
    chk("ovf_sticky", fifo_overflow, 1);

    // Soft clear; the 10 pushes end on the window's last cycle.
    irq_assert_thresh   = 10'd8;
    irq_deassert_thresh = 10'd2;
    for (int k = 0; k < 100 && (ecnt % 100) != 90; k++) cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h2000 + 32'(i), 1'b0);
    chk("sc_numel10", fifo_numel, 10);
    chk("sc_ovf_pre", fifo_overflow, 1);
    chk("sc_irq_pre", irq, 1);
    chk("sc_rate_pre", event_rate, 10);
    fifo_rst_n = 1'b0;
    evt_valid  = 1'b1;
    evt_data   = 32'hBEEF;
    tick();
    fifo_rst_n = 1'b1;
    evt_valid  = 1'b0;
    mdl.delete();
    chk("sc_numel", fifo_numel, 0);
    chk("sc_ovf", fifo_overflow, 0);
    chk("sc_irq", irq, 0);
    chk("sc_rdata", fifo_rdata, 0);
    chk("sc_rate", event_rate, 10);
    cyc(1'b0, '0, 1'b0);
    chk("sc_push_dropped", fifo_numel, 0);

    // IRQ hysteresis 8/2.
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h3000 + 32'(i), 1'b0);
    chk("irq_numel8", fifo_numel, 8);
    chk("irq_lag", irq, 0);
    cyc(1'b0, '0, 1'b0);
    chk("irq_rise", irq, 1);
    repeat (5) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("irq_numel3", fifo_numel, 3);
    chk("irq_hold3", irq, 1);
    cyc(1'b0, '0, 1'b1);
    chk("irq_numel2", fifo_numel, 2);
    chk("irq_fall_lag", irq, 1);
    cyc(1'b0, '0, 1'b0);
    chk("irq_fall", irq, 0);
    repeat (2) cyc(1'b0, '0, 1'b1);
    irq_assert_thresh = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h4000 + 32'(i), 1'b0);
      chk("irq_disabled", irq, 0);
    end
    repeat (20) cyc(1'b0, '0, 1'b1);
    chk("irq_drained", fifo_numel, 0);

    // Long interleaved traffic across several pointer wraps.
    pushed = 0;
    for (int i = 0; i < 20000 && pushed < 3000; i++) begin
      if ((i % 5) != 4 && mdl.size() < DEPTH) pushed++;
      cyc((i % 5) != 4, 32'(i) * 32'h9E3779B1, (i % 3) != 0);
    end
    chk("wrap_numel", fifo_numel, mdl.size());
    for (int k = 0; k < 2000 && mdl.size() != 0; k++) cyc(1'b0, '0, 1'b1);
    chk("wrap_drained", fifo_numel, 0);

    // Rate saturation on the 4096-cycle instance.
    for (int k = 0; k < 5000 && (ecnt % 4096) != 0; k++) tick();
    b_valid = 1'b1;
    b_rd_en = 1'b1;
    repeat (2000) tick();
    b_valid = 1'b0;
    b_rd_en = 1'b0;
    chk("b_numel", b_numel, 1);
    chk("b_rdata", b_rdata, 32'hCAFE);
    chk("b_ready", b_ready, 1);
    chk("b_irq", b_irq, 0);
    for (int k = 0; k < 5000 && (ecnt % 4096) != 4095; k++) tick();
    chk("b_rate_before", b_rate, 0);
    tick();
    chk("b_rate_sat", b_rate, 1023);
    chk("b_ovf", b_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
